cmp_seq_nbit: RTL and testbench
===============================

// Module: cmp_seq_nbit
// PURPOSE
//   Parametrised multi-cycle magnitude comparator for the ALU logical-operations group.
//   Compares two WIDTH-bit operands CHUNK bits per cycle, most significant chunk first.
//   Supports signed and unsigned modes, optional early exit, and valid/ready handshakes on both sides.
//   Result flags are one-hot equal/greater/less, plus the number of chunks examined.
// PARAMETERS
//   WIDTH       16  operand width in bits; must be a multiple of CHUNK
//   CHUNK        4  bits compared per cycle; NCHUNK = WIDTH/CHUNK; NCHUNK >= 1
//   EARLY_EXIT   1  1: finish at the first unequal chunk; 0: always scan all NCHUNK chunks
// PORTS
//   clk          in   1                    single clock; all state updates on posedge
//   rst          in   1                    synchronous, active-high reset
//   in_valid     in   1                    operands and mode are valid
//   in_ready     out  1                    block can accept operands (high only in IDLE)
//   inp1         in   WIDTH                operand A
//   inp2         in   WIDTH                operand B
//   signed_mode  in   1                    1: two's-complement compare; 0: unsigned compare
//   out_valid    out  1                    result flags and chunks_used are valid
//   out_ready    in   1                    consumer takes the result
//   equal        out  1                    A == B
//   greater      out  1                    A > B
//   less         out  1                    A < B
//   chunks_used  out  $clog2(NCHUNK+1)     number of chunks examined for this result
// BEHAVIOUR
//   - Reset: rst sampled high forces IDLE. It clears out_valid, equal, greater, less and chunks_used to 0.
//     in_ready=1 from the first cycle after reset. Reset overrides every other event, including mid-RUN or mid-DONE.
//   - FSM states:
//     - IDLE: in_ready=1.
//       - in_valid & in_ready at an edge (accept): latch inp1, inp2 and signed_mode; idx <= NCHUNK-1; go to RUN.
//       - Flags keep the previous result; out_valid stays 0.
//     - RUN: in_ready=0. Each cycle compares chunk idx of the latched operands.
//       - Signed mode, top chunk only: invert bit CHUNK-1 of both operands' chunks, then compare unsigned.
//       - Chunk unequal and EARLY_EXIT=1: register gt/lt from that chunk, eq=0, and go to DONE.
//       - EARLY_EXIT=0: the first unequal chunk's decision is kept sticky; later chunks cannot change it.
//       - idx==0 reached: go to DONE. Result is eq=1 if no chunk differed, otherwise the sticky decision.
//       - Otherwise idx <= idx-1.
//       - chunks_used counts compared chunks, 1..NCHUNK.
//     - DONE: out_valid=1; flags are exactly one-hot.
//       - Flags and chunks_used stay stable while out_ready=0.
//       - out_valid & out_ready at an edge: go to IDLE. out_valid drops on that edge; flags hold their values.
//       - in_valid is ignored in RUN and DONE. There is no same-cycle output pop and input accept.
//   - Latency: accept at edge E0 gives out_valid high after edge Ek, where k = chunks_used.
//     k = NCHUNK for equal operands or for EARLY_EXIT=0. Throughput: one result per k+2 cycles at most.
//   - Inputs are sampled only on the accept edge. Changes to inp1, inp2 or signed_mode during RUN have no effect.
//   - Boundaries:
//     - NCHUNK=1: single-cycle RUN.
//     - CHUNK=WIDTH is legal.
//     - Signed extremes (most negative vs all-ones, 0x8000 vs 0xFFFF) are ordered correctly by the top-chunk MSB inversion.
// STRUCTURE
//   - Shared package alu_cmp_pkg holds:
//     - the state encodings ST_IDLE, ST_RUN, ST_DONE (2 bits);
//     - the flag index constants CMP_EQ, CMP_GT, CMP_LT;
//     - a function cmp_clog2.
//   - Sub-module cmp_chunk: combinational, CHUNK-bit.
//     - Inputs: a, b, flip_msb.
//     - Outputs: eq, gt.
//     - One instance, fed by an idx-selected slice.
//   - Top level holds the FSM, operand registers, idx down-counter, sticky decision, chunks_used counter and output registers.
// TESTING  (WIDTH=16, CHUNK=4, EARLY_EXIT=1 unless stated)
//   1. Unsigned 0x000B vs 0x000B
//      -> equal=1, greater=0, less=0; chunks_used=4; out_valid rises 4 edges after accept.
//   2. Unsigned 0xF00F vs 0x0FF0
//      -> greater=1; chunks_used=1.
//      With EARLY_EXIT=0 -> greater=1; chunks_used=4.
//   3. 0x8000 vs 0x7FFF
//      -> unsigned: greater=1; signed: less=1; chunks_used=1 in both cases.
//      Signed 0xFFFF vs 0x0000 -> less=1.
//   4. Unsigned 0x1234 vs 0x1235
//      -> less=1; chunks_used=4.
//      Signed 0xFFFE vs 0xFFFF -> less=1; chunks_used=4.
//   5. Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands
//      -> out_valid, flags and chunks_used stable; in_ready=0; the new operands are not accepted.
//      Then out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
//   6. Assert rst for 1 cycle during RUN (after 2 chunks)
//      -> next cycle: out_valid=0; equal, greater, less all 0; chunks_used=0; in_ready=1.
//      A subsequent 0x000B vs 0x000B completes normally.

Source files
------------

// File: rtl/alu_cmp_pkg.sv
// Shared encodings and helpers for the multi-cycle ALU magnitude comparator.
package alu_cmp_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cmp_state_e;

  localparam int CMP_EQ = 0;
  localparam int CMP_GT = 1;
  localparam int CMP_LT = 2;

  function automatic int cmp_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/cmp_chunk.sv
// One CHUNK-bit unsigned compare; flip_msb turns it into a signed compare for the top chunk.
module cmp_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             flip_msb,
  output logic             eq,
  output logic             gt
);
  logic [CHUNK-1:0] msk, aa, bb;

  always_comb begin
    msk            = '0;
    msk[CHUNK-1]   = flip_msb;
    aa             = a ^ msk;
    bb             = b ^ msk;
    eq             = (aa == bb);
    gt             = (aa > bb);
  end
endmodule

// File: rtl/cmp_seq_nbit.sv
// Multi-cycle magnitude comparator: scans operands MS chunk first, one chunk per cycle.
module cmp_seq_nbit
  import alu_cmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHUNK      = 4,
  parameter int EARLY_EXIT = 1,
  localparam int NCHUNK    = WIDTH / CHUNK,
  localparam int CW        = cmp_clog2(NCHUNK + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             equal,
  output logic             greater,
  output logic             less,
  output logic [CW-1:0]    chunks_used
);
  localparam int IW = (NCHUNK > 1) ? cmp_clog2(NCHUNK) : 1;

  cmp_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d, cu_q, cu_d;
  logic             hit_q, hit_d, hgt_q, hgt_d;
  logic [2:0]       flags_q, flags_d;

  logic [CHUNK-1:0] ca, cb;
  logic             flip, c_eq, c_gt;

  always_comb begin
    ca   = CHUNK'(a_q >> (idx_q * CHUNK));
    cb   = CHUNK'(b_q >> (idx_q * CHUNK));
    flip = sgn_q && (idx_q == IW'(NCHUNK - 1));
  end

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (ca),
    .b        (cb),
    .flip_msb (flip),
    .eq       (c_eq),
    .gt       (c_gt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    hgt_d   = hgt_q;
    flags_d = flags_q;
    cu_d    = cu_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = inp1;
          b_d     = inp2;
          sgn_d   = signed_mode;
          idx_d   = IW'(NCHUNK - 1);
          cnt_d   = '0;
          hit_d   = 1'b0;
          hgt_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        // The first differing chunk decides; later chunks never override it.
        if (!hit_q && !c_eq) begin
          hit_d = 1'b1;
          hgt_d = c_gt;
        end
        if (((EARLY_EXIT != 0) && !c_eq) || (idx_q == '0)) begin
          state_d         = ST_DONE;
          flags_d[CMP_EQ] = !hit_d;
          flags_d[CMP_GT] = hit_d && hgt_d;
          flags_d[CMP_LT] = hit_d && !hgt_d;
          cu_d            = cnt_d;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      hgt_q   <= 1'b0;
      flags_q <= '0;
      cu_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      hgt_q   <= hgt_d;
      flags_q <= flags_d;
      cu_q    <= cu_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign equal       = flags_q[CMP_EQ];
  assign greater     = flags_q[CMP_GT];
  assign less        = flags_q[CMP_LT];
  assign chunks_used = cu_q;
endmodule

// File: tb/tb_cmp_seq_nbit.sv
// Scoreboard bench: an early-exit and a full-scan comparator driven side by side.
module tb_cmp_seq_nbit;
  logic        clk, rst;
  logic        in_valid, out_ready, signed_mode;
  logic [15:0] inp1, inp2;
  logic        ir1, ov1, eq1, gt1, lt1;
  logic        ir0, ov0, eq0, gt0, lt0;
  logic [2:0]  cu1, cu0;

  typedef struct {
    logic       eq, gt, lt;
    logic [2:0] cu;
  } exp_t;

  exp_t q1[$], q0[$];
  int   checks = 0, errors = 0;

  cmp_seq_nbit #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .inp1(inp1), .inp2(inp2), .signed_mode(signed_mode),
    .out_valid(ov1), .out_ready(out_ready),
    .equal(eq1), .greater(gt1), .less(lt1), .chunks_used(cu1));

  cmp_seq_nbit #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(0)) dut_full (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .inp1(inp1), .inp2(inp2), .signed_mode(signed_mode),
    .out_valid(ov0), .out_ready(out_ready),
    .equal(eq0), .greater(gt0), .less(lt0), .chunks_used(cu0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input bit early);
    exp_t        e;
    logic [15:0] d;
    int          h;
    e.gt = s ? ($signed(a) > $signed(b)) : (a > b);
    e.lt = s ? ($signed(a) < $signed(b)) : (a < b);
    e.eq = (a == b);
    d = a ^ b;
    h = -1;
    for (int i = 0; i < 16; i++) if (d[i]) h = i;
    e.cu = (!early || h < 0) ? 3'd4 : 3'(4 - h / 4);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (ov1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL early_unexpected_out got eq%0b gt%0b lt%0b cu%0d, none expected", eq1, gt1, lt1, cu1);
        end else begin
          exp_t e;
          e = q1.pop_front();
          if ({eq1, gt1, lt1, cu1} !== {e.eq, e.gt, e.lt, e.cu}) begin
            errors++;
            $display("FAIL early_result got eq%0b gt%0b lt%0b cu%0d want eq%0b gt%0b lt%0b cu%0d",
                     eq1, gt1, lt1, cu1, e.eq, e.gt, e.lt, e.cu);
          end
        end
      end
      if (ov0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL full_unexpected_out got eq%0b gt%0b lt%0b cu%0d, none expected", eq0, gt0, lt0, cu0);
        end else begin
          exp_t e;
          e = q0.pop_front();
          if ({eq0, gt0, lt0, cu0} !== {e.eq, e.gt, e.lt, e.cu}) begin
            errors++;
            $display("FAIL full_result got eq%0b gt%0b lt%0b cu%0d want eq%0b gt%0b lt%0b cu%0d",
                     eq0, gt0, lt0, cu0, e.eq, e.gt, e.lt, e.cu);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!(ir1 && ir0) && n < 30) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!(ir1 && ir0)) begin
      errors++;
      $display("FAIL idle_timeout got ir %0b/%0b want 1/1", ir1, ir0);
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t e1, e0;
    int   n;
    wait_idle();
    e1 = model(a, b, s, 1'b1);
    e0 = model(a, b, s, 1'b0);
    inp1 = a; inp2 = b; signed_mode = s; in_valid = 1'b1;
    q1.push_back(e1);
    q0.push_back(e0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    inp1 = ~a; inp2 = ~b; signed_mode = ~s;
    n = 0;
    while (!ov1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != int'(e1.cu)) begin
      errors++;
      $display("FAIL latency a=%h b=%h s=%0b got %0d edges want %0d", a, b, s, n, e1.cu);
    end
    n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (q1.size() != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout a=%h b=%h got pending %0d/%0d want 0/0", a, b, q1.size(), q0.size());
      q1.delete();
      q0.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    inp1 = '0; inp2 = '0; signed_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({ov1, eq1, gt1, lt1, cu1, ir1} !== {4'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got ov%0b eq%0b gt%0b lt%0b cu%0d ir%0b want 0 0 0 0 0 1",
               ov1, eq1, gt1, lt1, cu1, ir1);
    end
  endtask

  task automatic test_table();
    do_op(16'h000B, 16'h000B, 1'b0);
    do_op(16'hF00F, 16'h0FF0, 1'b0);
    do_op(16'h8000, 16'h7FFF, 1'b0);
    do_op(16'h8000, 16'h7FFF, 1'b1);
    do_op(16'hFFFF, 16'h0000, 1'b1);
    do_op(16'h1234, 16'h1235, 1'b0);
    do_op(16'hFFFE, 16'hFFFF, 1'b1);
    do_op(16'h8000, 16'hFFFF, 1'b1);
    do_op(16'h8000, 16'hFFFF, 1'b0);
    do_op(16'h7FFF, 16'h7FFF, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = (i % 3 == 0) ? (a ^ 16'(1 << $urandom_range(15))) : 16'($urandom);
      do_op(a, b, 1'($urandom_range(1)));
    end
  endtask

  task automatic test_backpressure();
    int n;
    wait_idle();
    out_ready = 1'b0;
    inp1 = 16'h1234; inp2 = 16'h1235; signed_mode = 1'b0; in_valid = 1'b1;
    q1.push_back(model(16'h1234, 16'h1235, 1'b0, 1'b1));
    q0.push_back(model(16'h1234, 16'h1235, 1'b0, 1'b0));
    @(posedge clk); #1 in_valid = 1'b0;
    n = 0;
    while (!(ov1 && ov0) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; inp1 = 16'h0001; inp2 = 16'hF000; signed_mode = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({ov1, eq1, gt1, lt1, cu1, ir1, ov0, lt0, cu0, ir0} !== {1'b1, 3'b001, 3'd4, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0}) begin
        errors++;
        $display("FAIL backpressure_hold c=%0d got ov%0b eq%0b gt%0b lt%0b cu%0d ir%0b full ov%0b lt%0b cu%0d ir%0b want 1 0 0 1 4 0 / 1 1 4 0",
                 c, ov1, eq1, gt1, lt1, cu1, ir1, ov0, lt0, cu0, ir0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ov1, ir1, ov0, ir0, lt1} !== 5'b01011) begin
      errors++;
      $display("FAIL backpressure_release got ov%0b ir%0b full ov%0b ir%0b lt%0b want 0 1 0 1 1",
               ov1, ir1, ov0, ir0, lt1);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ov1 || ov0 || q1.size() != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL backpressure_no_accept got ov %0b/%0b pending %0d/%0d want 0/0 0/0",
               ov1, ov0, q1.size(), q0.size());
    end
  endtask

  task automatic test_reset_mid_run();
    wait_idle();
    inp1 = 16'h000B; inp2 = 16'h000B; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++;
    if ({ov1, eq1, gt1, lt1, cu1, ir1, ov0, cu0, ir0} !== {4'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_run got ov%0b eq%0b gt%0b lt%0b cu%0d ir%0b full ov%0b cu%0d ir%0b want 0 0 0 0 0 1 / 0 0 1",
               ov1, eq1, gt1, lt1, cu1, ir1, ov0, cu0, ir0);
    end
    do_op(16'h000B, 16'h000B, 1'b0);
  endtask

  initial begin
    test_reset();
    test_table();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish before timeout");
    $fatal(1, "watchdog");
  end
endmodule
